irq_aggregator: RTL and testbench
=================================

# irq_aggregator

Interrupt aggregator that sits directly downstream of the interval timers and other peripheral IRQ sources and feeds one combined, maskable request line to the Nios II CPU. It latches up to 16 interrupt inputs in level or rising-edge mode, applies a mask, and reports the lowest-numbered active source as a vector. A total-event counter is also provided. Software reaches it through a 16-bit Avalon-MM slave with the same register width and read timing as the timer peripherals.

## Interface
- N_IRQ, 8: number of interrupt inputs, legal range 1..16; register bits at index N_IRQ and above read 0 and ignore writes.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  N_IRQ  peripheral requests, synchronous to clk; bit 0 is the highest priority.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  combined request to the CPU, registered.

## Operation
- Write strobe: chipselect && ~write_n. Reads have no side effects.
- Register map:
  - 0 PENDING: read pending[N_IRQ-1:0]. Writing 1 clears the edge-mode bits written; level-mode bits ignore the write.
  - 1 MASK: read/write; 1 = enabled.
  - 2 EDGE: read/write; 1 = rising-edge capture, 0 = level.
  - 3 ACTIVE: read-only, pending & mask.
  - 4 VECTOR: read-only. Bit 15 = any active. Bits 3:0 = index of the lowest set ACTIVE bit, or 0 when none is active.
  - 5 RAW: read-only, irq_d, the registered copy of irq_in.
  - 6 EVCOUNT: read-only count of captured events. Any write clears it to 0.
  - 7: reads 0; writes are ignored.
- irq_d <= irq_in every cycle. rise = irq_in & ~irq_d.
- Level-mode bit: pending[i] <= irq_in[i]. It tracks the source with one cycle of delay; software clears it at the source, for example by writing the timer status register.
- Edge-mode bit: pending[i] is set when rise[i] = 1 and holds until cleared by a PENDING write.
- A set on the same cycle as a W1C clear of that bit: the set wins, and the bit stays 1.
- Changing EDGE[i] from 1 to 0: the bit follows irq_in from the next cycle. Changing from 0 to 1: the current pending value is held, and it clears only by W1C.
- EVCOUNT: increments by 1 on every cycle in which at least one bit i < N_IRQ has rise[i] = 1. This applies whatever the mask or mode.
  - Several simultaneous rises count as 1.
  - The counter saturates at 16'hFFFF and does not wrap.
  - A clear on the same cycle as an increment: the clear wins, giving 0.
- irq <= |(pending & mask).

## Timing
- Reset values:
  - readdata 0, irq 0.
  - pending, mask, edge and irq_d all 0.
  - EVCOUNT 0.
- Reset is asynchronous. Asserting it mid-operation forces every value above immediately. The first updates take effect on the first rising clk after deassertion.
- Read latency: 1 cycle. readdata <= mux(address) at every edge, regardless of chipselect, matching the timer slaves. Data appears on the edge after the address is presented.
- Register writes take effect at the edge of the strobe. A read issued in the following cycle returns the new value.
- Interrupt latency, irq_in to irq:
  - irq_in rises before edge E.
  - irq_d and pending update at E.
  - irq asserts at E+1, so irq is 2 edges after irq_in rises.
- Deassertion latency:
  - Level mode: irq_in falls, pending clears 1 edge later, and irq drops 1 edge after that.
  - Edge mode: the W1C write at edge E clears pending at E, and irq drops at E+1.
- Mask write at edge E: irq follows at E+1.
- VECTOR, ACTIVE and PENDING reads reflect the state registered at the read edge. They may lag irq by up to 1 cycle.

## Test plan
- Reset check: assert reset mid-run with MASK = 16'h00FF and irq high → irq = 0 and readdata = 0 immediately. After release, reads of addresses 0–6 all return 0.
- Timer level source: with MASK = 1 and EDGE = 0, drive irq_in[0] high at cycle 10 → irq is 1 from cycle 12 and PENDING reads 16'h0001. Drop irq_in[0] at cycle 20 → irq is 0 from cycle 22, and EVCOUNT = 1.
- Edge mode with simultaneous events: with EDGE = 16'h0004 and MASK = 16'h0004, pulse irq_in[2] for 1 cycle → PENDING = 16'h0004 and irq stays high. Write PENDING = 16'h0004 on the same cycle as a new rise on bit 2 → the bit stays 1. A second W1C with no rise → PENDING = 0 and irq falls 1 cycle later.
- Priority vector: with MASK = 16'h00F0, hold irq_in = 16'h00A2 → ACTIVE = 16'h00A0 and VECTOR = 16'h8005. Clear MASK → VECTOR = 0 and irq = 0 one cycle later.
- Counter saturation and clear: generate 65,540 separate rise cycles → EVCOUNT = 16'hFFFF. A write to address 6 on the same cycle as a rise → 0.
- N_IRQ = 3 build: writing 16'hFFFF to MASK and EDGE → both read 16'h0007, and irq_in bits 15:3 have no effect.

Source files
------------

// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave bus of the interrupt aggregator: 3-bit word address, 16-bit data,
// registered read data.
interface irq_aggregator_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/irq_aggregator.sv
// Latches up to 16 level/edge interrupt sources, masks them into one CPU request and
// reports the lowest-numbered active source; also counts cycles with any rising input.
module irq_aggregator #(
    parameter int unsigned N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    irq_aggregator_if.slave  bus,
    output logic             irq
);

    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_edge;
    logic [N_IRQ-1:0] r_irq_d;
    logic [15:0]      r_evcount;
    logic [15:0]      r_readdata;
    logic             r_irq;

    logic             w_we;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_pending_d;
    logic [N_IRQ-1:0] w_active;
    logic [3:0]       w_vec_idx;
    logic [15:0]      w_rdata;

    assign w_we     = bus.chipselect && !bus.write_n;
    assign w_rise   = irq_in & ~r_irq_d;
    assign w_active = r_pending & r_mask;
    assign w_clr    = (w_we && bus.address == 3'd0) ? bus.writedata[N_IRQ-1:0] : '0;

    // Edge bits hold until W1C, with a same-cycle rise overriding the clear;
    // level bits simply track the source.
    assign w_pending_d = (r_edge & ((r_pending & ~w_clr) | w_rise)) | (~r_edge & irq_in);

    always_comb begin
        w_vec_idx = 4'd0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (bus.address)
            3'd0:    w_rdata = 16'(r_pending);
            3'd1:    w_rdata = 16'(r_mask);
            3'd2:    w_rdata = 16'(r_edge);
            3'd3:    w_rdata = 16'(w_active);
            3'd4:    w_rdata = {|w_active, 11'd0, w_vec_idx};
            3'd5:    w_rdata = 16'(r_irq_d);
            3'd6:    w_rdata = r_evcount;
            default: w_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_irq_d    <= '0;
            r_evcount  <= 16'h0000;
            r_readdata <= 16'h0000;
            r_irq      <= 1'b0;
        end else begin
            r_irq_d    <= irq_in;
            r_pending  <= w_pending_d;
            r_irq      <= |w_active;
            r_readdata <= w_rdata;
            if (w_we && bus.address == 3'd1) begin
                r_mask <= bus.writedata[N_IRQ-1:0];
            end
            if (w_we && bus.address == 3'd2) begin
                r_edge <= bus.writedata[N_IRQ-1:0];
            end
            // Clear beats a coincident increment; the count saturates rather than wraps.
            if (w_we && bus.address == 3'd6) begin
                r_evcount <= 16'h0000;
            end else if (|w_rise && r_evcount != 16'hFFFF) begin
                r_evcount <= r_evcount + 16'd1;
            end
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: directed scenarios plus randomized traffic,
// compared each cycle against a bit-level behavioural model of the register rules.
module tb_irq_aggregator;

    localparam int NI = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_in;
    logic        irq;
    logic [15:0] irq_in3;
    logic        irq3;

    irq_aggregator_if bus_if ();
    irq_aggregator_if bus3_if ();

    irq_aggregator #(.N_IRQ(NI)) u_dut (
        .clk    (clk),
        .reset  (rst),
        .irq_in (irq_in),
        .bus    (bus_if),
        .irq    (irq)
    );

    irq_aggregator #(.N_IRQ(3)) u_dut3 (
        .clk    (clk),
        .reset  (rst),
        .irq_in (irq_in3[2:0]),
        .bus    (bus3_if),
        .irq    (irq3)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: one bit per source, state kept in plain arrays.
    bit          m_p [16];
    bit          m_m [16];
    bit          m_e [16];
    bit          m_d [16];
    int          m_ev;
    bit          m_irq;
    logic [15:0] m_rd;

    function automatic logic [15:0] model_read(input int a);
        logic [15:0] v;
        int first;
        v = 16'h0000;
        first = -1;
        for (int i = 0; i < NI; i++) begin
            case (a)
                0: v[i] = m_p[i];
                1: v[i] = m_m[i];
                2: v[i] = m_e[i];
                3: v[i] = m_p[i] & m_m[i];
                5: v[i] = m_d[i];
                default: ;
            endcase
            if (m_p[i] && m_m[i] && first < 0) first = i;
        end
        if (a == 4 && first >= 0) v = 16'h8000 | 16'(first);
        if (a == 6) v = 16'(m_ev);
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    m_p[i] = 0; m_m[i] = 0; m_e[i] = 0; m_d[i] = 0;
                end
                m_ev = 0; m_irq = 0; m_rd = 16'h0000;
            end else begin
                bit we, anyr, rise;
                int a;
                a  = int'(bus_if.address);
                we = bus_if.chipselect && !bus_if.write_n;
                m_rd  = model_read(a);
                m_irq = 0;
                anyr  = 0;
                for (int i = 0; i < NI; i++) begin
                    if (m_p[i] && m_m[i]) m_irq = 1;
                end
                for (int i = 0; i < NI; i++) begin
                    rise = irq_in[i] && !m_d[i];
                    if (rise) anyr = 1;
                    if (m_e[i]) m_p[i] = (m_p[i] && !(we && a == 0 && bus_if.writedata[i])) || rise;
                    else        m_p[i] = irq_in[i];
                    if (we && a == 1) m_m[i] = bus_if.writedata[i];
                    if (we && a == 2) m_e[i] = bus_if.writedata[i];
                    m_d[i] = irq_in[i];
                end
                if (we && a == 6)           m_ev = 0;
                else if (anyr && m_ev < 65535) m_ev = m_ev + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && chk_en) begin
                check("model_irq", 32'(irq), 32'(m_irq));
                check("model_rdata", 32'(bus_if.readdata), 32'(m_rd));
            end
        end
    end

    // Bus tasks are entered at a negedge and return at the following negedge.
    task automatic bus_write(input bit sel, input int a, input logic [15:0] d);
        if (sel) begin
            bus3_if.address = 3'(a); bus3_if.chipselect = 1; bus3_if.write_n = 0;
            bus3_if.writedata = d;
        end else begin
            bus_if.address = 3'(a); bus_if.chipselect = 1; bus_if.write_n = 0;
            bus_if.writedata = d;
        end
        @(negedge clk);
        bus_if.chipselect = 0;  bus_if.write_n = 1;
        bus3_if.chipselect = 0; bus3_if.write_n = 1;
    endtask

    task automatic bus_read(input bit sel, input int a, output logic [15:0] d);
        if (sel) begin
            bus3_if.address = 3'(a); bus3_if.chipselect = 1; bus3_if.write_n = 1;
        end else begin
            bus_if.address = 3'(a); bus_if.chipselect = 1; bus_if.write_n = 1;
        end
        @(negedge clk);
        d = sel ? bus3_if.readdata : bus_if.readdata;
        bus_if.chipselect = 0;
        bus3_if.chipselect = 0;
    endtask

    logic [15:0] rd;

    initial begin
        rst = 1; irq_in = 0; irq_in3 = 0;
        bus_if.address = 0;  bus_if.chipselect = 0;  bus_if.write_n = 1;  bus_if.writedata = 0;
        bus3_if.address = 0; bus3_if.chipselect = 0; bus3_if.write_n = 1; bus3_if.writedata = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk_en = 1;
        check("reset_irq", 32'(irq), 0);
        bus_read(0, 1, rd); check("reset_mask", 32'(rd), 0);

        // Level source on bit 0.
        bus_write(0, 1, 16'h0001);
        irq_in = 8'h01;
        @(negedge clk); check("lvl_irq_lat1", 32'(irq), 0);
        @(negedge clk); check("lvl_irq_lat2", 32'(irq), 1);
        bus_read(0, 0, rd); check("lvl_pending", 32'(rd), 32'h0001);
        irq_in = 8'h00;
        @(negedge clk); check("lvl_drop1", 32'(irq), 1);
        @(negedge clk); check("lvl_drop2", 32'(irq), 0);
        bus_read(0, 6, rd); check("lvl_evcount", 32'(rd), 1);

        // Edge mode on bit 2 with a W1C colliding with a new rise.
        bus_write(0, 2, 16'h0004);
        bus_write(0, 1, 16'h0004);
        irq_in = 8'h04; @(negedge clk);
        irq_in = 8'h00; repeat (2) @(negedge clk);
        bus_read(0, 0, rd); check("edge_pending", 32'(rd), 32'h0004);
        check("edge_irq_held", 32'(irq), 1);
        irq_in = 8'h04;
        bus_write(0, 0, 16'h0004);
        irq_in = 8'h00;
        bus_read(0, 0, rd); check("edge_set_wins", 32'(rd), 32'h0004);
        bus_write(0, 0, 16'h0004);
        check("edge_w1c_irq1", 32'(irq), 1);
        @(negedge clk); check("edge_w1c_irq2", 32'(irq), 0);
        bus_read(0, 0, rd); check("edge_cleared", 32'(rd), 0);

        // Priority vector.
        bus_write(0, 2, 16'h0000);
        bus_write(0, 1, 16'h00F0);
        irq_in = 8'hA2; repeat (2) @(negedge clk);
        bus_read(0, 3, rd); check("prio_active", 32'(rd), 32'h00A0);
        bus_read(0, 4, rd); check("prio_vector", 32'(rd), 32'h8005);
        check("prio_irq", 32'(irq), 1);
        bus_write(0, 1, 16'h0000);
        check("prio_mask_irq1", 32'(irq), 1);
        @(negedge clk); check("prio_mask_irq2", 32'(irq), 0);
        bus_read(0, 4, rd); check("prio_vector_off", 32'(rd), 0);
        irq_in = 8'h00; @(negedge clk);

        // Alternate bits 0 and 1 so every cycle carries a rise.
        for (int k = 0; k < 65540; k++) begin
            irq_in = (k % 2 == 0) ? 8'h01 : 8'h02;
            @(negedge clk);
        end
        irq_in = 8'h00; @(negedge clk);
        bus_read(0, 6, rd); check("ev_saturate", 32'(rd), 32'hFFFF);
        irq_in = 8'h01;
        bus_write(0, 6, 16'h1234);
        irq_in = 8'h00;
        bus_read(0, 6, rd); check("ev_clear_wins", 32'(rd), 0);

        // Randomized traffic, checked by the per-cycle model comparison.
        for (int k = 0; k < 3000; k++) begin
            irq_in = 8'($urandom);
            bus_if.address   = 3'($urandom_range(0, 7));
            bus_if.writedata = 16'($urandom);
            bus_if.chipselect = ($urandom_range(0, 3) != 0);
            bus_if.write_n    = ($urandom_range(0, 9) >= 3);
            @(negedge clk);
        end
        bus_if.chipselect = 0; bus_if.write_n = 1; irq_in = 0;

        // Mid-run asynchronous reset.
        bus_write(0, 2, 16'h0000);
        bus_write(0, 1, 16'h00FF);
        irq_in = 8'h01; repeat (3) @(negedge clk);
        check("rst_pre_irq", 32'(irq), 1);
        #2 rst = 1; irq_in = 8'h00;
        #1 check("rst_async_irq", 32'(irq), 0);
        check("rst_async_rdata", 32'(bus_if.readdata), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        for (int a = 0; a < 7; a++) begin
            bus_read(0, a, rd); check($sformatf("rst_read%0d", a), 32'(rd), 0);
        end

        // Three-input build: unused register bits and inputs are inert.
        bus_write(1, 1, 16'hFFFF);
        bus_write(1, 2, 16'hFFFF);
        bus_read(1, 1, rd); check("n3_mask", 32'(rd), 32'h0007);
        bus_read(1, 2, rd); check("n3_edge", 32'(rd), 32'h0007);
        irq_in3 = 16'hFFF8; repeat (3) @(negedge clk);
        check("n3_irq_high_bits", 32'(irq3), 0);
        bus_read(1, 0, rd); check("n3_pending", 32'(rd), 0);
        bus_read(1, 6, rd); check("n3_evcount", 32'(rd), 0);
        irq_in3 = 16'hFFFC; repeat (2) @(negedge clk);
        check("n3_irq_bit2", 32'(irq3), 1);
        bus_read(1, 4, rd); check("n3_vector", 32'(rd), 32'h8002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
